// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback arbiter slice.
package wb_pkg;
  localparam int unsigned WB_DATA_WIDTH  = 32;
  localparam int unsigned WB_RADDR_WIDTH = 5;

  typedef struct packed {
    logic [WB_DATA_WIDTH-1:0]  data;
    logic [WB_RADDR_WIDTH-1:0] rd;
  } wb_entry_t;

  typedef enum logic {
    WB_SRC_EXEC = 1'b0,
    WB_SRC_MEM  = 1'b1
  } wb_src_t;
endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO: power-of-two depth, DEPTH-aware count, synchronous clear.
module wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: mem-priority over exec, registered write.
// Optional starvation guard for exec enabled by WB_STARVE_GUARD_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = WB_DATA_WIDTH,
  parameter int unsigned RADDR_WIDTH  = WB_RADDR_WIDTH,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   exec_valid,
  output logic                   exec_ready,
  input  logic [DATA_WIDTH-1:0]  exec_data,
  input  logic [RADDR_WIDTH-1:0] exec_rd,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [DATA_WIDTH-1:0]  mem_data,
  input  logic [RADDR_WIDTH-1:0] mem_rd,
  output logic                   rf_we,
  output logic [RADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]  rf_wdata,
  output logic                   grant_mem
);
  localparam int unsigned EW = DATA_WIDTH + RADDR_WIDTH;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [EW-1:0]          exec_head, mem_head;
  logic                   exec_full, exec_empty, mem_full, mem_empty;
  logic [CW-1:0]          exec_count, mem_count;
  logic                   grant_exec, grant_mem_c, force_exec;
  wb_src_t                sel;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [RADDR_WIDTH-1:0] sel_rd;
  logic                   unused_counts;

  assign unused_counts = ^{exec_count, mem_count};
  assign exec_ready    = !exec_full && !flush;
  assign mem_ready     = !mem_full && !flush;

  wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_exec_fifo (
    .clk(clk), .reset(reset), .clear(flush),
    .push(exec_valid && exec_ready), .pop(grant_exec),
    .din({exec_data, exec_rd}), .dout(exec_head),
    .full(exec_full), .empty(exec_empty), .count(exec_count)
  );

  wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_mem_fifo (
    .clk(clk), .reset(reset), .clear(flush),
    .push(mem_valid && mem_ready), .pop(grant_mem_c),
    .din({mem_data, mem_rd}), .dout(mem_head),
    .full(mem_full), .empty(mem_empty), .count(mem_count)
  );

`ifdef WB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // Counts cycles exec was waiting while mem took the port; saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (flush || grant_exec) begin
      starve_cnt <= '0;
    end else if (grant_mem_c && !exec_empty && starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign force_exec = (starve_cnt == SW'(STARVE_LIMIT));
`else
  localparam int unsigned unused_starve_limit = STARVE_LIMIT;
  assign force_exec = 1'b0;
`endif

  always_comb begin
    grant_exec  = !flush && !exec_empty && (mem_empty || force_exec);
    grant_mem_c = !flush && !mem_empty && !grant_exec;
    sel         = grant_exec ? WB_SRC_EXEC : WB_SRC_MEM;
    {sel_data, sel_rd} = (sel == WB_SRC_MEM) ? mem_head : exec_head;
  end

  // x0 entries are consumed as grants but never raise the write enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      grant_mem <= 1'b0;
    end else begin
      rf_we     <= 1'b0;
      grant_mem <= 1'b0;
      if (grant_exec || grant_mem_c) begin
        rf_we     <= (sel_rd != '0);
        rf_waddr  <= sel_rd;
        rf_wdata  <= sel_data;
        grant_mem <= grant_mem_c;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter; honours WB_STARVE_GUARD_EN when defined.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        gm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        exec_valid = 1'b0, mem_valid = 1'b0;
  logic        exec_ready, mem_ready;
  logic [31:0] exec_data = '0, mem_data = '0;
  logic [4:0]  exec_rd = '0, mem_rd = '0;
  logic        rf_we, grant_mem;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  wb_entry_t src_ex[$], src_mem[$];
  wb_entry_t mex[$], mmem[$];
  exp_t      exp_q[$];
  int        starve = 0;
  bit        en_ex = 1'b1, en_mem = 1'b1;

  wb_arbiter #(.DATA_WIDTH(32), .RADDR_WIDTH(5), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_data(exec_data), .exec_rd(exec_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data), .mem_rd(mem_rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_mem(grant_mem)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Sources: hold the head offer stable until accepted.
  always @(posedge clk) begin
    #2;
    exec_valid = en_ex && (src_ex.size() > 0);
    if (exec_valid) begin exec_data = src_ex[0].data; exec_rd = src_ex[0].rd; end
    mem_valid = en_mem && (src_mem.size() > 0);
    if (mem_valid) begin mem_data = src_mem[0].data; mem_rd = src_mem[0].rd; end
  end

  // Reference model: pushes the expected registered write for every edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mex.delete(); mmem.delete(); exp_q.delete(); src_ex.delete(); src_mem.delete();
      starve = 0;
    end else begin
      wb_entry_t ent;
      exp_t e;
      bit acc_e, acc_m, ge, gm;
      acc_e = exec_valid && !flush && (mex.size() < DEPTH);
      acc_m = mem_valid && !flush && (mmem.size() < DEPTH);
      e = '{we: 1'b0, addr: 5'd0, data: 32'd0, gm: 1'b0};
      if (flush) begin
        mex.delete(); mmem.delete(); starve = 0;
      end else begin
        ge = (mex.size() > 0) && ((mmem.size() == 0) || (GUARD && starve == LIMIT));
        gm = (mmem.size() > 0) && !ge;
        if (ge) begin
          ent = mex.pop_front();
          e.we = (ent.rd != 5'd0); e.addr = ent.rd; e.data = ent.data;
          starve = 0;
        end else if (gm) begin
          ent = mmem.pop_front();
          e.we = (ent.rd != 5'd0); e.addr = ent.rd; e.data = ent.data; e.gm = 1'b1;
          if (mex.size() > 0 && starve < LIMIT) starve++;
        end
        if (acc_e) mex.push_back('{data: exec_data, rd: exec_rd});
        if (acc_m) mmem.push_back('{data: mem_data, rd: mem_rd});
      end
      if (acc_e) void'(src_ex.pop_front());
      if (acc_m) void'(src_mem.pop_front());
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (!reset && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (rf_we !== e.we) begin
        errors++; $display("FAIL sb_rf_we: got %0b want %0b at %0t", rf_we, e.we, $time);
      end
      checks++;
      if (grant_mem !== e.gm) begin
        errors++; $display("FAIL sb_grant_mem: got %0b want %0b at %0t", grant_mem, e.gm, $time);
      end
      if (e.we) begin
        checks++;
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          errors++;
          $display("FAIL sb_write: got rd=%0d data=%h want rd=%0d data=%h at %0t",
                   rf_waddr, rf_wdata, e.addr, e.data, $time);
        end
      end
      checks++;
      if (exec_ready !== (mex.size() < DEPTH && !flush) || mem_ready !== (mmem.size() < DEPTH && !flush)) begin
        errors++;
        $display("FAIL sb_ready: got exec=%0b mem=%0b want exec=%0b mem=%0b at %0t", exec_ready, mem_ready,
                 (mex.size() < DEPTH && !flush), (mmem.size() < DEPTH && !flush), $time);
      end
    end
  end

  task automatic align();
    @(posedge clk); #3;
  endtask

  task automatic pulse_flush();
    align(); flush = 1'b1;
    align(); flush = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((src_ex.size() + src_mem.size() + mex.size() + mmem.size()) > 0 && n < 400) begin
      @(posedge clk); n++;
    end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL drain: still busy after %0d cycles, required idle", n); end
    repeat (3) @(posedge clk);
    #3;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || grant_mem !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got we=%0b rd=%0d data=%h gm=%0b want all 0",
                         rf_we, rf_waddr, rf_wdata, grant_mem);
    end
    align(); reset = 1'b0;
    @(negedge clk);
    checks++;
    if (exec_ready !== 1'b1 || mem_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got exec=%0b mem=%0b want 1 1", exec_ready, mem_ready);
    end
  endtask

  task automatic test_latency(input logic [4:0] rd, input logic [31:0] data);
    align();
    src_ex.push_back('{data: data, rd: rd});
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL latency_early: got we=%0b want 0", rf_we); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== rd || rf_wdata !== data || grant_mem !== 1'b0) begin
      errors++; $display("FAIL latency_write: got we=%0b rd=%0d data=%h gm=%0b want 1 %0d %h 0",
                         rf_we, rf_waddr, rf_wdata, grant_mem, rd, data);
    end
    drain();
  endtask

  task automatic test_priority();
    int unsigned got = 0, cyc = 0;
    logic want;
    pulse_flush();
    for (int unsigned i = 0; i < 12; i++) begin
      src_ex.push_back('{data: 32'h1000_0000 | i, rd: 5'(1 + i)});
      src_mem.push_back('{data: 32'h2000_0000 | i, rd: 5'(17 + i)});
    end
    while (got < 8 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (rf_we === 1'b1) begin
        want = GUARD ? (got % 4 != 3) : 1'b1;
        checks++;
        if (grant_mem !== want) begin
          errors++; $display("FAIL priority_pattern[%0d]: got gm=%0b want %0b", got, grant_mem, want);
        end
        got++;
      end
    end
    checks++;
    if (got < 8) begin errors++; $display("FAIL priority_count: got %0d writes want 8", got); end
    drain();
  endtask

  task automatic test_full();
    pulse_flush();
    for (int unsigned i = 0; i < 8; i++) src_ex.push_back('{data: 32'h3000_0000 | i, rd: 5'(1 + i)});
    for (int unsigned i = 0; i < 16; i++) src_mem.push_back('{data: 32'h4000_0000 | i, rd: 5'(10 + i)});
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exec_ready !== 1'b0 || exec_valid !== 1'b1 || mem_ready !== 1'b1) begin
      errors++; $display("FAIL full_holdoff: got exec_ready=%0b exec_valid=%0b mem_ready=%0b want 0 1 1",
                         exec_ready, exec_valid, mem_ready);
    end
    drain();
  endtask

  task automatic test_x0();
    align();
    src_ex.push_back('{data: 32'hDEAD, rd: 5'd0});
    src_ex.push_back('{data: 32'h33, rd: 5'd3});
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_suppressed: got we=%0b want 0", rf_we); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h33) begin
      errors++; $display("FAIL x0_next: got we=%0b rd=%0d data=%h want 1 3 00000033", rf_we, rf_waddr, rf_wdata);
    end
    drain();
  endtask

  task automatic test_flush();
    pulse_flush();
    for (int unsigned i = 0; i < 10; i++) begin
      src_ex.push_back('{data: 32'h5000_0000 | i, rd: 5'(1 + i)});
      src_mem.push_back('{data: 32'h6000_0000 | i, rd: 5'(12 + i)});
    end
    repeat (4) @(posedge clk);
    #3;
    flush = 1'b1; en_ex = 1'b0; en_mem = 1'b0;
    @(negedge clk);
    checks++;
    if (exec_ready !== 1'b0 || mem_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready_low: got exec=%0b mem=%0b want 0 0", exec_ready, mem_ready);
    end
    align();
    flush = 1'b0; src_ex.delete(); src_mem.delete();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || exec_ready !== 1'b1 || mem_ready !== 1'b1) begin
      errors++; $display("FAIL flush_after: got we=%0b exec=%0b mem=%0b want 0 1 1", rf_we, exec_ready, mem_ready);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0) begin errors++; $display("FAIL flush_stale[%0d]: got we=%0b want 0", i, rf_we); end
    end
    en_ex = 1'b1; en_mem = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    align();
    for (int unsigned i = 0; i < 20; i++) src_ex.push_back('{data: 32'h7000_0000 | i, rd: 5'(1 + i)});
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1) begin errors++; $display("FAIL midreset_pre: got we=%0b want 1", rf_we); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || grant_mem !== 1'b0) begin
      errors++; $display("FAIL midreset_async: got we=%0b rd=%0d data=%h gm=%0b want all 0",
                         rf_we, rf_waddr, rf_wdata, grant_mem);
    end
    align();
    src_ex.delete(); src_mem.delete();
    align();
    reset = 1'b0;
    test_latency(5'd9, 32'h99);
  endtask

  initial begin
    test_reset();
    test_latency(5'd5, 32'h11);
    test_priority();
    test_full();
    test_x0();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
